xram_arb: RTL and testbench
===========================

// Module: xram_arb
// PURPOSE
//  Single-port XRAM with a two-master arbiter. It sits directly downstream of the
//  memwr copy engine (its xram_* port) and the CPU/xiommu XRAM port, and serialises
//  their byte accesses onto one internal byte array.
//  Fair round-robin arbitration with a programmable wait-state count gives the
//  memwr engine a realistic multi-cycle ack.
// PARAMETERS
//  ADDR_W       16  address width; array depth is 2**ADDR_W bytes
//  WAIT_CYCLES  1   extra cycles between grant and ack (0..15)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  m0_stb       in   1       CPU request; held until m0_ack
//  m0_wr        in   1       CPU 1=write 0=read
//  m0_addr      in   ADDR_W  CPU byte address
//  m0_data_in   in   8       CPU write data
//  m0_data_out  out  8       CPU read data, registered
//  m0_ack       out  1       CPU one-cycle completion pulse
//  m1_stb       in   1       memwr request (memwr xram_stb)
//  m1_wr        in   1       memwr xram_wr
//  m1_addr      in   ADDR_W  memwr xram_addr
//  m1_data_in   in   8       memwr xram_data_out
//  m1_data_out  out  8       to memwr xram_data_in, registered
//  m1_ack       out  1       to memwr xram_ack
//  busy         out  1       high in S_WAIT/S_ACK
//  grant        out  1       master owning current/last access (0=CPU, 1=memwr)
// BEHAVIOUR
//  Reset:
//   - state=S_IDLE; wait count=0; both acks 0; both data_outs 8'h00.
//   - last_grant=1, so m0 wins the first tie; grant=0; busy=0.
//   - Array contents are NOT reset.
//  FSM S_IDLE/S_WAIT/S_ACK:
//   - S_IDLE, any stb high: choose winner; latch winner addr/wr/data_in into access
//     regs; grant<=winner; last_grant<=winner.
//     Next state is S_WAIT when WAIT_CYCLES>0, else S_ACK.
//   - S_IDLE, no stb: stay in S_IDLE.
//   - S_WAIT: count 1..WAIT_CYCLES; go to S_ACK on the cycle the count reaches
//     WAIT_CYCLES.
//   - S_ACK: exactly one cycle. Raise ack of the granted master only, then S_IDLE.
//  Arbitration:
//   - One requester: it wins.
//   - Both requesting: winner = ~last_grant (strict alternation).
//  Latency:
//   - stb sampled in S_IDLE at cycle T gives ack at T+1+WAIT_CYCLES.
//   - Back-to-back accesses from one master: 2+WAIT_CYCLES cycles each.
//   - The S_IDLE cycle after S_ACK re-samples stb; memwr's incremented address is
//     therefore used.
//  Data:
//   - Write commits latched data to latched addr on the S_ACK edge.
//   - Read: granted data_out <= array[latched addr], valid in the S_ACK cycle.
//     Held until that master's next read.
//   - Other master's data_out is untouched.
//   - Addr/data changes after grant are ignored (latched copies used).
//  Boundaries:
//   - stb dropped mid-access: access still completes (write committed, ack pulsed).
//     Masters must hold stb until ack.
//   - Address 2**ADDR_W-1 is legal; there is no wrap logic.
//   - Request arriving in S_WAIT/S_ACK waits for S_IDLE and is never lost.
//   - Reset mid-access: aborted, no ack, pending write not committed.
//   - m0_ack and m1_ack are never high together.
// TESTING
//  1. WAIT_CYCLES=1; m1 writes 8'hA5 @16'h1000 at T.
//     -> m1_ack at T+2 only; m1 read of 16'h1000 returns 8'hA5 with m1_ack.
//  2. After reset, m0 and m1 request together, held for 4 accesses.
//     -> grants 0,1,0,1; acks never overlap.
//  3. WAIT_CYCLES=0; m1 streams reads 16'h2000..16'h2003 (preloaded 01..04).
//     -> ack every 2 cycles; data 01,02,03,04.
//  4. m0 write 8'h3C @16'hFFFF, then m1 read @16'hFFFF.
//     -> m1_data_out=8'h3C; m0_data_out keeps its previous value.
//  5. rst asserted during S_WAIT of m1 write 8'h77 @16'h0010.
//     -> no ack; array[16'h0010] unchanged; outputs at reset values immediately.
//  6. m0 drops stb one cycle after grant during a write of 8'h55 @16'h0020.
//     -> m0_ack still pulses; array[16'h0020]=8'h55.

Source files
------------

// File: rtl/xram_arb.sv
// xram_arb: single-port byte XRAM shared by CPU (m0) and memwr (m1) through a round-robin arbiter with wait states
module xram_arb #(
  parameter int ADDR_W = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_data_in,
  output logic [7:0]        m0_data_out,
  output logic              m0_ack,
  input  logic              m1_stb,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_data_in,
  output logic [7:0]        m1_data_out,
  output logic              m1_ack,
  output logic              busy,
  output logic              grant
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_grant, win, who, acc_wr, cur_wr, go_ack;
  logic [ADDR_W-1:0] acc_addr, cur_addr;
  logic [7:0] acc_data, cur_data;
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always_comb begin
    win = (m0_stb && m1_stb) ? ~last_grant : m1_stb;
    who = (state == S_IDLE) ? win : grant;
    cur_wr = (state == S_IDLE) ? (win ? m1_wr : m0_wr) : acc_wr;
    cur_addr = (state == S_IDLE) ? (win ? m1_addr : m0_addr) : acc_addr;
    cur_data = (state == S_IDLE) ? (win ? m1_data_in : m0_data_in) : acc_data;
    state_nx = (state == S_IDLE) ? ((m0_stb || m1_stb) ? ((WC != 4'd0) ? S_WAIT : S_ACK) : S_IDLE) :
               (state == S_WAIT) ? ((cnt == WC) ? S_ACK : S_WAIT) : S_IDLE;
    go_ack = !rst && (state_nx == S_ACK);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      last_grant <= 1'b1;
      grant <= 1'b0;
      acc_wr <= 1'b0;
      acc_addr <= '0;
      acc_data <= 8'h00;
      m0_data_out <= 8'h00;
      m1_data_out <= 8'h00;
    end else begin
      state <= state_nx;
      cnt <= (state_nx == S_WAIT) ? cnt + 4'd1 : 4'd0;
      if (state == S_IDLE && (m0_stb || m1_stb)) begin
        grant <= win;
        last_grant <= win;
        acc_wr <= cur_wr;
        acc_addr <= cur_addr;
        acc_data <= cur_data;
      end
      if (go_ack && !cur_wr && !who) m0_data_out <= mem[cur_addr];
      if (go_ack && !cur_wr && who) m1_data_out <= mem[cur_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (go_ack && cur_wr) mem[cur_addr] <= cur_data;
  end
  assign m0_ack = (state == S_ACK) && !grant;
  assign m1_ack = (state == S_ACK) && grant;
  assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_xram_arb.sv
// tb_xram_arb: scoreboard bench for xram_arb, instance 0 with one wait state, instance 1 with none
module tb_xram_arb;
  typedef struct {int inst; bit m; bit rd; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_stb [2], m0_wr [2], m1_stb [2], m1_wr [2];
  logic [15:0] m0_addr [2], m1_addr [2];
  logic [7:0] m0_din [2], m1_din [2];
  wire [7:0] m0_dout [2], m1_dout [2];
  wire m0_ack [2], m1_ack [2], busy [2], grant [2];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  xram_arb #(.ADDR_W(16), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb[0]), .m0_wr(m0_wr[0]), .m0_addr(m0_addr[0]), .m0_data_in(m0_din[0]),
    .m0_data_out(m0_dout[0]), .m0_ack(m0_ack[0]),
    .m1_stb(m1_stb[0]), .m1_wr(m1_wr[0]), .m1_addr(m1_addr[0]), .m1_data_in(m1_din[0]),
    .m1_data_out(m1_dout[0]), .m1_ack(m1_ack[0]),
    .busy(busy[0]), .grant(grant[0])
  );
  xram_arb #(.ADDR_W(16), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb[1]), .m0_wr(m0_wr[1]), .m0_addr(m0_addr[1]), .m0_data_in(m0_din[1]),
    .m0_data_out(m0_dout[1]), .m0_ack(m0_ack[1]),
    .m1_stb(m1_stb[1]), .m1_wr(m1_wr[1]), .m1_addr(m1_addr[1]), .m1_data_in(m1_din[1]),
    .m1_data_out(m1_dout[1]), .m1_ack(m1_ack[1]),
    .busy(busy[1]), .grant(grant[1])
  );
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] got_d;
    for (int i = 0; i < 2; i++) begin
      if (m0_ack[i] && m1_ack[i]) begin
        errors++;
        $display("FAIL ack_overlap inst %0d: both acks high", i);
      end
      if (m0_ack[i] || m1_ack[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack inst %0d: m0_ack=%0b m1_ack=%0b with nothing expected", i, m0_ack[i], m1_ack[i]);
        end else begin
          e = sb.pop_front();
          got_d = m1_ack[i] ? m1_dout[i] : m0_dout[i];
          if (e.inst != i || e.m != m1_ack[i] || (e.rd && got_d !== e.d))
            begin
              errors++;
              $display("FAIL ack_result: got inst %0d master %0b data %h, expected inst %0d master %0b data %h (read=%0b)",
                       i, m1_ack[i], got_d, e.inst, e.m, e.d, e.rd);
            end
        end
      end
    end
  end
  task automatic do_acc(input int i, input bit m, input bit wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] ed);
    int lat;
    bit got;
    @(posedge clk); #1;
    if (m) begin m1_stb[i] = 1'b1; m1_wr[i] = wr; m1_addr[i] = a; m1_din[i] = d; end
    else begin m0_stb[i] = 1'b1; m0_wr[i] = wr; m0_addr[i] = a; m0_din[i] = d; end
    sb.push_back('{i, m, !wr, ed});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = m ? m1_ack[i] : m0_ack[i];
    end
    checks++;
    if (!got || lat != ((i == 0) ? 3 : 2)) begin
      errors++;
      $display("FAIL latency inst %0d master %0b addr %h: ack=%0b after %0d, expected ack after %0d", i, m, a, got, lat, (i == 0) ? 3 : 2);
    end
    @(posedge clk); #1;
    if (m) m1_stb[i] = 1'b0;
    else m0_stb[i] = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m0_ack[i] !== 1'b0 || m1_ack[i] !== 1'b0 || busy[i] !== 1'b0 || grant[i] !== 1'b0 ||
          m0_dout[i] !== 8'h00 || m1_dout[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_state inst %0d: acks %b%b busy %b grant %b d0 %h d1 %h, expected all zero",
                 i, m0_ack[i], m1_ack[i], busy[i], grant[i], m0_dout[i], m1_dout[i]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic test_write_read;
    do_acc(0, 1'b1, 1'b1, 16'h1000, 8'hA5, 8'h00);
    do_acc(0, 1'b1, 1'b0, 16'h1000, 8'h00, 8'hA5);
  endtask
  task automatic test_arbitration;
    int n;
    int cyc;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m0_stb[0] = 1'b1; m0_wr[0] = 1'b1; m0_addr[0] = 16'h3000; m0_din[0] = 8'h11;
    m1_stb[0] = 1'b1; m1_wr[0] = 1'b1; m1_addr[0] = 16'h3001; m1_din[0] = 8'h22;
    for (int k = 0; k < 4; k++) sb.push_back('{0, k[0], 1'b0, 8'h00});
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m0_ack[0] || m1_ack[0]) begin
        checks++;
        if (grant[0] !== n[0]) begin
          errors++;
          $display("FAIL grant_seq access %0d: grant %0b, expected %0b", n, grant[0], n[0]);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL arb_count: %0d acks, expected 4", n);
    end
    @(posedge clk); #1;
    m0_stb[0] = 1'b0;
    m1_stb[0] = 1'b0;
  endtask
  task automatic test_stream;
    int n;
    int cyc;
    int last;
    for (int k = 0; k < 4; k++) do_acc(1, 1'b0, 1'b1, 16'h2000 + 16'(k), 8'(k + 1), 8'h00);
    @(posedge clk); #1;
    m1_stb[1] = 1'b1; m1_wr[1] = 1'b0; m1_addr[1] = 16'h2000;
    for (int k = 0; k < 4; k++) sb.push_back('{1, 1'b1, 1'b1, 8'(k + 1)});
    n = 0;
    cyc = 0;
    last = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m1_ack[1]) begin
        if (n > 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL stream_interval ack %0d: %0d cycles, expected 2", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        @(posedge clk); #1 m1_addr[1] = m1_addr[1] + 16'd1;
      end
    end
    m1_stb[1] = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL stream_count: %0d acks, expected 4", n);
    end
  endtask
  task automatic test_top_addr;
    do_acc(0, 1'b0, 1'b0, 16'h1000, 8'h00, 8'hA5);
    do_acc(0, 1'b0, 1'b1, 16'hFFFF, 8'h3C, 8'h00);
    do_acc(0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C);
    checks++;
    if (m0_dout[0] !== 8'hA5) begin
      errors++;
      $display("FAIL m0_data_hold: m0_data_out %h, expected a5", m0_dout[0]);
    end
  endtask
  task automatic test_reset_mid;
    do_acc(0, 1'b1, 1'b1, 16'h0010, 8'h99, 8'h00);
    @(posedge clk); #1;
    m1_stb[0] = 1'b1; m1_wr[0] = 1'b1; m1_addr[0] = 16'h0010; m1_din[0] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || grant[0] !== 1'b1 || m1_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: busy %b grant %b ack %b, expected 1 1 0", busy[0], grant[0], m1_ack[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || grant[0] !== 1'b0 || m0_ack[0] !== 1'b0 || m1_ack[0] !== 1'b0 ||
        m0_dout[0] !== 8'h00 || m1_dout[0] !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy %b grant %b acks %b%b d0 %h d1 %h, expected all zero",
               busy[0], grant[0], m0_ack[0], m1_ack[0], m0_dout[0], m1_dout[0]);
    end
    m1_stb[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_acc(0, 1'b1, 1'b0, 16'h0010, 8'h00, 8'h99);
  endtask
  task automatic test_stb_drop;
    int cyc;
    bit got;
    @(posedge clk); #1;
    m0_stb[0] = 1'b1; m0_wr[0] = 1'b1; m0_addr[0] = 16'h0020; m0_din[0] = 8'h55;
    sb.push_back('{0, 1'b0, 1'b0, 8'h00});
    @(posedge clk); #1;
    m0_stb[0] = 1'b0; m0_addr[0] = 16'h0021; m0_din[0] = 8'hEE;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = m0_ack[0];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL stb_drop_ack: no m0_ack after %0d cycles, expected one", cyc);
    end
    do_acc(0, 1'b1, 1'b0, 16'h0020, 8'h00, 8'h55);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      m0_stb[i] = 1'b0; m0_wr[i] = 1'b0; m0_addr[i] = 16'h0000; m0_din[i] = 8'h00;
      m1_stb[i] = 1'b0; m1_wr[i] = 1'b0; m1_addr[i] = 16'h0000; m1_din[i] = 8'h00;
    end
    test_reset;
    test_write_read;
    test_arbitration;
    test_stream;
    test_top_addr;
    test_reset_mid;
    test_stb_drop;
    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected acks never seen, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
